// File: rtl/msk_refresh_pipe.sv
// Masked refresh with valid/ready flow control: XORs a fresh zero-sum mask into
// an NBITS-wide, D-share Boolean sharing over LAT pipeline stages.
module msk_refresh_pipe #(
  parameter int D     = 2,
  parameter int NBITS = 1,
  parameter int LAT   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NBITS*D-1:0]                  in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NBITS*((D == 2) ? 1 : D)-1:0] rnd,
  output logic [NBITS*D-1:0]                  out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int RND_PER_BIT = (D == 2) ? 1 : D;
  localparam int W           = NBITS * D;

  logic [W-1:0]   mask;
  logic           advance;
  logic [LAT-1:0] stage_valid;
  logic [W-1:0]   stage_data [LAT];

  if (D == 2) begin : g_mask_d2
    always_comb begin
      mask = '0;
      for (int b = 0; b < NBITS; b++) begin
        mask[b*D]   = rnd[b];
        mask[b*D+1] = rnd[b];
      end
    end
  end else begin : g_mask_ring
    // Ring refresh: each random bit lands in two neighbouring shares, so the mask XORs to 0.
    always_comb begin
      mask = '0;
      for (int b = 0; b < NBITS; b++) begin
        for (int i = 0; i < D; i++) begin
          mask[b*D+i] = rnd[b*RND_PER_BIT+i] ^ rnd[b*RND_PER_BIT+((i+D-1)%D)];
        end
      end
    end
  end

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_valid[LAT-1];
  assign out_data  = stage_data[LAT-1];

  if (LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_valid   <= '0;
        stage_data[0] <= '0;
      end else if (advance) begin
        stage_valid <= in_valid;
        if (in_valid) begin
          stage_data[0] <= in_data ^ mask;
        end
      end
    end
  end else begin : g_latn
    // Shares and mask stay in separate registers until the final stage combines them.
    logic [W-1:0] stage_mask [LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_valid <= '0;
        for (int s = 0; s < LAT; s++) begin
          stage_data[s] <= '0;
        end
        for (int s = 0; s < LAT-1; s++) begin
          stage_mask[s] <= '0;
        end
      end else if (advance) begin
        stage_valid <= {stage_valid[LAT-2:0], in_valid};
        if (in_valid) begin
          stage_data[0] <= in_data;
          stage_mask[0] <= mask;
        end
        for (int s = 1; s < LAT-1; s++) begin
          if (stage_valid[s-1]) begin
            stage_data[s] <= stage_data[s-1];
            stage_mask[s] <= stage_mask[s-1];
          end
        end
        if (stage_valid[LAT-2]) begin
          stage_data[LAT-1] <= stage_data[LAT-2] ^ stage_mask[LAT-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_msk_refresh_pipe.sv
// Bench for msk_refresh_pipe: three configurations checked every cycle against a
// queue-based reference model, plus literal expectations from hand calculation.
module tb_msk_refresh_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tin [3];
  logic [31:0] trnd [3];
  logic        tv [3];
  logic        tor [3];

  logic [7:0]  od0;
  logic [2:0]  od1;
  logic [31:0] od2;
  logic        ov0, ov1, ov2, ir0, ir1, ir2;

  msk_refresh_pipe #(.D(2), .NBITS(4), .LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(tin[0][7:0]), .in_valid(tv[0]), .in_ready(ir0),
    .rnd(trnd[0][3:0]), .out_data(od0), .out_valid(ov0), .out_ready(tor[0]));
  msk_refresh_pipe #(.D(3), .NBITS(1), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(tin[1][2:0]), .in_valid(tv[1]), .in_ready(ir1),
    .rnd(trnd[1][2:0]), .out_data(od1), .out_valid(ov1), .out_ready(tor[1]));
  msk_refresh_pipe #(.D(4), .NBITS(8), .LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(tin[2]), .in_valid(tv[2]), .in_ready(ir2),
    .rnd(trnd[2]), .out_data(od2), .out_valid(ov2), .out_ready(tor[2]));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-instance FIFO of in-flight items with the number of
  // pipeline advances each has seen since acceptance.
  int          cnt [3];
  int          hd [3];
  int          age [3][16];
  logic [31:0] fdat [3][16];
  logic [7:0]  fun [3][16];
  logic [31:0] last [3];

  function automatic int pd(int n);
    return (n == 0) ? 2 : (n == 1) ? 3 : 4;
  endfunction
  function automatic int pn(int n);
    return (n == 0) ? 4 : (n == 1) ? 1 : 8;
  endfunction
  function automatic int pl(int n);
    return (n == 0) ? 2 : (n == 1) ? 1 : 3;
  endfunction
  function automatic logic [31:0] wmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] dout(int n);
    return (n == 0) ? {24'd0, od0} : (n == 1) ? {29'd0, od1} : od2;
  endfunction
  function automatic logic dvalid(int n);
    return (n == 0) ? ov0 : (n == 1) ? ov1 : ov2;
  endfunction
  function automatic logic dready(int n);
    return (n == 0) ? ir0 : (n == 1) ? ir1 : ir2;
  endfunction

  function automatic logic [31:0] refresh(int d, int nb, logic [31:0] x, logic [31:0] r);
    logic [31:0] y;
    logic m;
    y = x;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < d; i++) begin
        if (d == 2) m = r[b];
        else m = r[b*d+i] ^ r[b*d+((i+d-1)%d)];
        y[b*d+i] = y[b*d+i] ^ m;
      end
    end
    return y;
  endfunction

  function automatic logic [7:0] unshare(int d, int nb, logic [31:0] x);
    logic [7:0] u;
    u = '0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < d; i++) u[b] = u[b] ^ x[b*d+i];
    end
    return u;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      cnt[n] = 0;
      hd[n] = 0;
      last[n] = '0;
    end
  endtask

  function automatic logic model_valid(int n);
    return (cnt[n] > 0) && (age[n][hd[n]] == pl(n) - 1);
  endfunction

  task automatic model_step(int n);
    logic ev;
    int s;
    ev = model_valid(n);
    if (!ev || tor[n]) begin
      if (ev) begin
        hd[n] = (hd[n] + 1) % 16;
        cnt[n]--;
      end
      for (int k = 0; k < cnt[n]; k++) begin
        s = (hd[n] + k) % 16;
        age[n][s]++;
        if (age[n][s] == pl(n) - 1) last[n] = fdat[n][s];
      end
      if (tv[n]) begin
        s = (hd[n] + cnt[n]) % 16;
        age[n][s] = 0;
        fdat[n][s] = refresh(pd(n), pn(n), tin[n], trnd[n]);
        fun[n][s] = unshare(pd(n), pn(n), tin[n]);
        cnt[n]++;
        if (pl(n) == 1) last[n] = fdat[n][s];
      end
    end
  endtask

  task automatic compare_all();
    logic ev;
    for (int n = 0; n < 3; n++) begin
      ev = model_valid(n);
      check($sformatf("out_valid[%0d]", n), {31'd0, dvalid(n)}, {31'd0, ev});
      check($sformatf("in_ready[%0d]", n), {31'd0, dready(n)}, {31'd0, (!ev || tor[n])});
      check($sformatf("out_data[%0d]", n), dout(n), last[n]);
      if (ev)
        check($sformatf("unshared[%0d]", n), {24'd0, unshare(pd(n), pn(n), dout(n))},
              {24'd0, fun[n][hd[n]]});
    end
  endtask

  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int n = 0; n < 3; n++) model_step(n);
    #1;
  endtask

  task automatic drive(int n, logic v, logic [31:0] d, logic [31:0] r, logic ordy);
    tv[n] = v;
    tin[n] = d & wmask(pn(n) * pd(n));
    trnd[n] = r & wmask(pn(n) * ((pd(n) == 2) ? 1 : pd(n)));
    tor[n] = ordy;
  endtask

  task automatic idle_all();
    for (int n = 0; n < 3; n++) drive(n, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic drive_random(int n, int pv, int pr);
    drive(n, ($urandom_range(0, 99) < pv), $urandom, $urandom, ($urandom_range(0, 99) < pr));
  endtask

  initial begin
    model_reset();
    idle_all();
    repeat (2) cycle();
    check("reset out_valid", {31'd0, ov2}, 32'd0);
    check("reset out_data", od2, 32'd0);
    check("reset in_ready", {31'd0, ir0}, 32'd1);
    rst_n = 1'b1;

    // D=2, LAT=2: 8'h5A with rnd 4'b0101 must emerge as 8'h69 one cycle later.
    drive(0, 1'b1, 32'h5A, 32'h5, 1'b1);
    cycle();
    drive(0, 1'b0, 32'h00, 32'h0, 1'b1);
    cycle();
    check("d2 out_data", {24'd0, od0}, 32'h69);
    check("d2 out_valid", {31'd0, ov0}, 32'd1);
    cycle();
    check("d2 single-cycle valid", {31'd0, ov0}, 32'd0);

    // D=3, LAT=1: 3'b000 with rnd 3'b001 gives 3'b011.
    drive(1, 1'b1, 32'h0, 32'h1, 1'b1);
    cycle();
    idle_all();
    check("d3 out_data", {29'd0, od1}, 32'h3);
    check("d3 zero-sum", {31'd0, ^od1}, 32'd0);
    cycle();

    // Backpressure on the LAT=2 instance for 5 cycles with in_valid held high.
    drive(0, 1'b1, $urandom, $urandom, 1'b1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'b0);
      cycle();
    end
    check("stall in_ready", {31'd0, ir0}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'b1);
      cycle();
    end
    idle_all();
    repeat (3) cycle();

    // Bubbles: three empty cycles between items.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'b1);
      drive(2, 1'b1, $urandom, $urandom, 1'b1);
      cycle();
      idle_all();
      repeat (3) cycle();
    end

    // Reset with two items in flight in the LAT=3 instance.
    drive(2, 1'b1, $urandom, $urandom, 1'b1);
    cycle();
    drive(2, 1'b1, $urandom, $urandom, 1'b1);
    cycle();
    idle_all();
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'd0, ov2}, 32'd0);
    check("async rst out_data", od2, 32'd0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check("post-reset idle", {31'd0, ov2}, 32'd0);

    // 1000 back-to-back transfers on the D=4, LAT=3 instance; others random.
    for (int k = 0; k < 1000; k++) begin
      drive(2, 1'b1, $urandom, $urandom, 1'b1);
      drive_random(0, 60, 70);
      drive_random(1, 60, 70);
      cycle();
    end
    idle_all();
    repeat (4) cycle();

    // Mixed random flow control on all instances.
    for (int k = 0; k < 800; k++) begin
      for (int n = 0; n < 3; n++) drive_random(n, 70, 60);
      cycle();
    end
    idle_all();
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
